// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: branch-unit state encoding and
// control-flow target arithmetic.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } br_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Conditional-branch target: offset is in words, sign-extended.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    logic [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc + PC_INC + off;
  endfunction

  function automatic logic [31:0] j_target(input logic [31:0] pc, input logic [25:0] jidx);
    logic [31:0] seq;
    seq = pc + PC_INC;
    return {seq[31:28], jidx, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage control-flow inputs and IF redirect / pipeline-control outputs
// of the branch resolution unit.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_is_beq;
  logic             ex_is_bne;
  logic             ex_is_j;
  logic [31:0]      ex_pc;
  logic [15:0]      ex_imm;
  logic [25:0]      ex_jidx;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             operand_ready;
  logic             branch;
  logic             branch_taken;
  logic [31:0]      target_address;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             stall_ex;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  // Producer of the redirect (the branch resolution unit itself).
  modport master (
    input  ex_valid, ex_is_beq, ex_is_bne, ex_is_j, ex_pc, ex_imm, ex_jidx,
    input  rs_val, rt_val, operand_ready,
    output branch, branch_taken, target_address, flush_if_id, flush_id_ex,
    output stall_ex, branch_count, taken_count
  );

  // EX stage / instruction fetch side.
  modport slave (
    output ex_valid, ex_is_beq, ex_is_bne, ex_is_j, ex_pc, ex_imm, ex_jidx,
    output rs_val, rt_val, operand_ready,
    input  branch, branch_taken, target_address, flush_if_id, flush_id_ex,
    input  stall_ex, branch_count, taken_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count register: clear wins, then increment unless saturated.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: resolves BEQ/BNE/J, issues the registered IF
// redirect, squashes the wrong path and stalls EX on outstanding operands.
module branch_resolve_unit
  import mips_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_unit_if.master bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  br_state_t   state_r;
  br_state_t   state_next_s;
  logic [1:0]  fcnt_r;
  logic [1:0]  fcnt_next_s;
  logic        cf_s;
  logic        resolve_s;
  logic        stall_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic        branch_r;
  logic        taken_r;
  logic [31:0] target_r;
  logic        flush_r;

  assign cf_s = bus.ex_valid & (bus.ex_is_beq | bus.ex_is_bne | bus.ex_is_j);

  // Direction and redirect target of the instruction currently in EX.
  always_comb begin
    taken_s  = 1'b0;
    target_s = bus.ex_pc + PC_INC;
    if (bus.ex_is_j) begin
      taken_s  = 1'b1;
      target_s = j_target(bus.ex_pc, bus.ex_jidx);
    end else if (bus.ex_is_beq || bus.ex_is_bne) begin
      taken_s  = bus.ex_is_beq ? (bus.rs_val == bus.rt_val) : (bus.rs_val != bus.rt_val);
      target_s = taken_s ? br_target(bus.ex_pc, bus.ex_imm) : bus.ex_pc + PC_INC;
    end else begin
      taken_s  = 1'b0;
      target_s = bus.ex_pc + PC_INC;
    end
  end

  // Next state, flush countdown, resolve strobe and EX stall.
  always_comb begin
    state_next_s = state_r;
    fcnt_next_s  = fcnt_r;
    resolve_s    = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE, WAIT: begin
        if (!cf_s) begin
          state_next_s = IDLE;
        end else if (bus.ex_is_j || bus.operand_ready) begin
          resolve_s = 1'b1;
          if (taken_s) begin
            state_next_s = FLUSH;
            fcnt_next_s  = FLUSH_LOAD;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          // EX is frozen, so the held inputs are resolved once ready rises.
          state_next_s = WAIT;
          stall_s      = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_r <= 2'd1) begin
          state_next_s = IDLE;
          fcnt_next_s  = 2'd0;
        end else begin
          state_next_s = FLUSH;
          fcnt_next_s  = fcnt_r - 2'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        fcnt_next_s  = 2'd0;
      end
    endcase
  end

  // State and registered redirect / flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      fcnt_r   <= 2'd0;
      branch_r <= 1'b0;
      taken_r  <= 1'b0;
      target_r <= 32'd0;
      flush_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      fcnt_r   <= fcnt_next_s;
      branch_r <= resolve_s;
      taken_r  <= resolve_s & taken_s;
      target_r <= resolve_s ? target_s : target_r;
      flush_r  <= (state_next_s == FLUSH);
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .inc (resolve_s),
    .clr (rst),
    .q   (bus.branch_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .inc (resolve_s & taken_s),
    .clr (rst),
    .q   (bus.taken_count)
  );

  assign bus.branch         = branch_r;
  assign bus.branch_taken   = taken_r;
  assign bus.target_address = target_r;
  assign bus.flush_if_id    = flush_r;
  assign bus.flush_id_ex    = flush_r;
  assign bus.stall_ex       = stall_s;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit: a 16-bit counter instance
// for the main scenarios and a 2-bit counter instance for saturation.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(16)) bus ();
  branch_resolve_unit_if #(.CNT_W(2))  bus2 ();

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0; bus.ex_is_beq = 1'b0; bus.ex_is_bne = 1'b0; bus.ex_is_j = 1'b0;
    bus.ex_pc = 32'd0; bus.ex_imm = 16'd0; bus.ex_jidx = 26'd0;
    bus.rs_val = 32'd0; bus.rt_val = 32'd0; bus.operand_ready = 1'b0;
    bus2.ex_valid = 1'b0; bus2.ex_is_beq = 1'b0; bus2.ex_is_bne = 1'b0; bus2.ex_is_j = 1'b0;
    bus2.ex_pc = 32'd0; bus2.ex_imm = 16'd0; bus2.ex_jidx = 26'd0;
    bus2.rs_val = 32'd0; bus2.rt_val = 32'd0; bus2.operand_ready = 1'b0;
    #1;
  endtask

  // kind: 0 = BEQ, 1 = BNE, 2 = J
  task automatic set_cf(input int kind, input logic [31:0] pc, input logic [15:0] imm,
                        input logic [25:0] jidx, input logic [31:0] rs, input logic [31:0] rt,
                        input logic rdy);
    bus.ex_valid = 1'b1;
    bus.ex_is_beq = (kind == 0); bus.ex_is_bne = (kind == 1); bus.ex_is_j = (kind == 2);
    bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_jidx = jidx;
    bus.rs_val = rs; bus.rt_val = rt; bus.operand_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %0b want 0", bus.branch); end
    vectors++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b want 0", bus.branch_taken); end
    vectors++; if (bus.target_address !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", bus.target_address); end
    vectors++; if ({bus.flush_if_id, bus.flush_id_ex, bus.stall_ex} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.flush_if_id, bus.flush_id_ex, bus.stall_ex}); end
    vectors++; if (bus.branch_count !== 16'd0 || bus.taken_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.branch_count, bus.taken_count); end
  endtask

  task automatic test_beq_taken();
    set_cf(0, 32'h100, 16'h0004, 26'd0, 32'd5, 32'd5, 1'b1);
    vectors++; if (bus.stall_ex !== 1'b0) begin errors++; $display("FAIL beq_nostall: got %0b want 0", bus.stall_ex); end
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b11) begin errors++; $display("FAIL beq_strobe: got %b want 11", {bus.branch, bus.branch_taken}); end
    vectors++; if (bus.target_address !== 32'h114) begin errors++; $display("FAIL beq_target: got %h want 00000114", bus.target_address); end
    vectors++; if ({bus.flush_if_id, bus.flush_id_ex} !== 2'b11) begin errors++; $display("FAIL beq_flush1: got %b want 11", {bus.flush_if_id, bus.flush_id_ex}); end
    vectors++; if (bus.taken_count !== 16'd1 || bus.branch_count !== 16'd1) begin errors++; $display("FAIL beq_counts: got %0d/%0d want 1/1", bus.branch_count, bus.taken_count); end
    tick();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b00) begin errors++; $display("FAIL beq_strobe_once: got %b want 00", {bus.branch, bus.branch_taken}); end
    vectors++; if ({bus.flush_if_id, bus.flush_id_ex} !== 2'b11) begin errors++; $display("FAIL beq_flush2: got %b want 11", {bus.flush_if_id, bus.flush_id_ex}); end
    vectors++; if (bus.target_address !== 32'h114) begin errors++; $display("FAIL beq_target_hold: got %h want 00000114", bus.target_address); end
    tick();
    vectors++; if ({bus.flush_if_id, bus.flush_id_ex} !== 2'b00) begin errors++; $display("FAIL beq_flush_end: got %b want 00", {bus.flush_if_id, bus.flush_id_ex}); end
  endtask

  task automatic test_bne_not_taken();
    do_reset();
    set_cf(1, 32'h200, 16'hFFFE, 26'd0, 32'd7, 32'd7, 1'b1);
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b10) begin errors++; $display("FAIL bne_strobe: got %b want 10", {bus.branch, bus.branch_taken}); end
    vectors++; if (bus.target_address !== 32'h204) begin errors++; $display("FAIL bne_target: got %h want 00000204", bus.target_address); end
    vectors++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin errors++; $display("FAIL bne_noflush: got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); end
    vectors++; if (bus.branch_count !== 16'd1 || bus.taken_count !== 16'd0) begin errors++; $display("FAIL bne_counts: got %0d/%0d want 1/0", bus.branch_count, bus.taken_count); end
    tick();
    vectors++; if (bus.branch !== 1'b0 || bus.flush_if_id !== 1'b0) begin errors++; $display("FAIL bne_after: got %b%b want 00", bus.branch, bus.flush_if_id); end
  endtask

  task automatic test_operand_stall();
    set_cf(0, 32'h300, 16'h0001, 26'd0, 32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.stall_ex !== 1'b1) begin errors++; $display("FAIL stall_cycle%0d: got %0b want 1", i, bus.stall_ex); end
      vectors++; if (bus.branch !== 1'b0) begin errors++; $display("FAIL stall_nostrobe%0d: got %0b want 0", i, bus.branch); end
      tick();
    end
    bus.operand_ready = 1'b1;
    #1;
    vectors++; if (bus.stall_ex !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b want 0", bus.stall_ex); end
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b11) begin errors++; $display("FAIL stall_strobe: got %b want 11", {bus.branch, bus.branch_taken}); end
    vectors++; if (bus.target_address !== 32'h308) begin errors++; $display("FAIL stall_target: got %h want 00000308", bus.target_address); end
    vectors++; if (bus.branch_count !== 16'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", bus.branch_count); end
    tick();
    tick();
  endtask

  task automatic test_jump_wrap();
    set_cf(2, 32'hF000_0000, 16'd0, 26'h0000010, 32'd1, 32'd2, 1'b0);
    vectors++; if (bus.stall_ex !== 1'b0) begin errors++; $display("FAIL j_nostall: got %0b want 0", bus.stall_ex); end
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b11) begin errors++; $display("FAIL j_strobe: got %b want 11", {bus.branch, bus.branch_taken}); end
    vectors++; if (bus.target_address !== 32'hF000_0040) begin errors++; $display("FAIL j_target: got %h want f0000040", bus.target_address); end
    tick();
    tick();
    set_cf(0, 32'hFFFF_FFFC, 16'h0000, 26'd0, 32'hA5, 32'hA5, 1'b1);
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken} !== 2'b11) begin errors++; $display("FAIL wrap_strobe: got %b want 11", {bus.branch, bus.branch_taken}); end
    vectors++; if (bus.target_address !== 32'h0000_0000) begin errors++; $display("FAIL wrap_target: got %h want 00000000", bus.target_address); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    set_cf(1, 32'h500, 16'h0010, 26'd0, 32'd3, 32'd3, 1'b1);
    tick();
    set_cf(0, 32'h504, 16'h0010, 26'd0, 32'd3, 32'd4, 1'b1);
    vectors++; if ({bus.branch, bus.target_address} !== {1'b1, 32'h504}) begin errors++; $display("FAIL b2b_first: got %0b/%h want 1/00000504", bus.branch, bus.target_address); end
    tick();
    idle();
    vectors++; if ({bus.branch, bus.branch_taken, bus.target_address} !== {2'b10, 32'h508}) begin errors++; $display("FAIL b2b_second: got %b/%h want 10/00000508", {bus.branch, bus.branch_taken}, bus.target_address); end
  endtask

  task automatic test_squash();
    do_reset();
    set_cf(0, 32'h400, 16'h0008, 26'd0, 32'd1, 32'd1, 1'b1);
    tick();
    vectors++; if (bus.target_address !== 32'h424 || bus.taken_count !== 16'd1) begin errors++; $display("FAIL squash_first: got %h/%0d want 00000424/1", bus.target_address, bus.taken_count); end
    set_cf(1, 32'h800, 16'h0020, 26'd0, 32'd1, 32'd2, 1'b1);
    tick();
    vectors++; if (bus.branch !== 1'b0 || bus.flush_if_id !== 1'b1) begin errors++; $display("FAIL squash_c1: got branch %0b flush %0b want 0/1", bus.branch, bus.flush_if_id); end
    tick();
    idle();
    vectors++; if (bus.branch !== 1'b0 || bus.flush_if_id !== 1'b0) begin errors++; $display("FAIL squash_c2: got branch %0b flush %0b want 0/0", bus.branch, bus.flush_if_id); end
    vectors++; if (bus.branch_count !== 16'd1 || bus.taken_count !== 16'd1) begin errors++; $display("FAIL squash_counts: got %0d/%0d want 1/1", bus.branch_count, bus.taken_count); end
    vectors++; if (bus.target_address !== 32'h424) begin errors++; $display("FAIL squash_target: got %h want 00000424", bus.target_address); end
  endtask

  task automatic test_reset_in_wait();
    set_cf(0, 32'h600, 16'h0002, 26'd0, 32'd4, 32'd4, 1'b0);
    tick();
    vectors++; if (bus.stall_ex !== 1'b1) begin errors++; $display("FAIL rstwait_stall: got %0b want 1", bus.stall_ex); end
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    vectors++; if ({bus.branch, bus.branch_taken, bus.flush_if_id, bus.flush_id_ex, bus.stall_ex} !== 5'b0) begin errors++; $display("FAIL rstwait_ctrl: got %b want 00000", {bus.branch, bus.branch_taken, bus.flush_if_id, bus.flush_id_ex, bus.stall_ex}); end
    vectors++; if (bus.target_address !== 32'h0 || bus.branch_count !== 16'd0 || bus.taken_count !== 16'd0) begin errors++; $display("FAIL rstwait_data: got %h/%0d/%0d want 0/0/0", bus.target_address, bus.branch_count, bus.taken_count); end
    tick();
    vectors++; if (bus.branch !== 1'b0) begin errors++; $display("FAIL rstwait_nostrobe: got %0b want 0", bus.branch); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      bus2.ex_valid = 1'b1; bus2.ex_is_j = 1'b1; bus2.ex_pc = 32'h1000; bus2.ex_jidx = 26'(n);
      tick();
      bus2.ex_valid = 1'b0; bus2.ex_is_j = 1'b0;
      exp_cnt = (n >= 3) ? 2'd3 : 2'(n);
      vectors++; if (bus2.taken_count !== exp_cnt || bus2.branch_count !== exp_cnt) begin errors++; $display("FAIL sat_count%0d: got %0d/%0d want %0d/%0d", n, bus2.branch_count, bus2.taken_count, exp_cnt, exp_cnt); end
      tick();
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_operand_stall();
    test_jump_wrap();
    test_back_to_back();
    test_squash();
    test_reset_in_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch resolution unit for the 5-stage MIPS core. It sits in the EX stage and is the producing end of the IF-stage redirect interface: it resolves BEQ/BNE/J and drives `branch`, `branch_taken` and the redirect target to instruction fetch. It squashes wrong-path instructions, stalls EX while branch operands are outstanding, and keeps saturating branch and taken counters for debug.

## Interface
- `FLUSH_CYCLES`, 2: cycles for which wrong-path flush is held after a taken redirect (1..3).
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  core clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  EX holds a valid instruction this cycle.
- `ex_is_beq` / `ex_is_bne` / `ex_is_j`  in  1 each  decoded control-flow type. At most one is set.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_imm`  in  16  branch offset, in words, signed.
- `ex_jidx`  in  26  jump index field.
- `rs_val`, `rt_val`  in  32 each  forwarded operands.
- `operand_ready`  in  1  forwarding unit confirms that `rs_val` and `rt_val` are final.
- `branch`  out  1  redirect strobe to IF.
- `branch_taken`  out  1  the resolved direction.
- `target_address`  out  32  redirect PC.
- `flush_if_id`, `flush_id_ex`  out  1 each  squash the pipeline registers.
- `stall_ex`  out  1  hold EX and the earlier stages.
- `branch_count`, `taken_count`  out  `CNT_W` each  statistics.

## Operation
- A control-flow instruction (CF) is `ex_valid` together with any one of the `is_*` inputs.
- States:
  - IDLE
  - WAIT: a CF is pending and its operands are not ready.
  - FLUSH: a countdown that squashes the wrong path.
- Transitions:
  - IDLE, CF arrives, `operand_ready`=1: the CF resolves this cycle. Go to FLUSH if it is taken, otherwise stay in IDLE.
  - IDLE, CF arrives, `operand_ready`=0: go to WAIT. `stall_ex`=1 combinationally in that same cycle.
  - WAIT: `stall_ex`=1 while `operand_ready`=0. When it rises, resolve with the held inputs (EX is frozen by the stall) and go to FLUSH or IDLE as above.
  - FLUSH: a counter loads `FLUSH_CYCLES` at entry. While in FLUSH, `flush_if_id`=`flush_id_ex`=1 and `ex_valid` is ignored, because those instructions are wrong-path. Go to IDLE when the counter hits 0.
- Direction rules:
  - BEQ is taken when `rs_val`==`rt_val`.
  - BNE is taken when they differ.
  - J is always taken. Operands are not needed, so `operand_ready` is ignored for J.
- Target arithmetic, all 32-bit with wrap-around modulo 2^32:
  - Branch: `ex_pc`+4+(sext(`ex_imm`)<<2).
  - J: {(`ex_pc`+4)[31:28], `ex_jidx`, 2'b00}.
  - Not-taken: `ex_pc`+4.
- Counters:
  - `branch_count` increments once per resolved CF, saturating at all-ones.
  - `taken_count` increments per taken CF, saturating at all-ones.
- Reset mid-operation aborts WAIT/FLUSH, returns to IDLE and clears the counters.

## Timing
- Reset values: every output is 0, the state is IDLE, and the counters are 0.
- The resolve cycle is called R.
- `branch`, `branch_taken` and `target_address` are registered. They are valid for exactly one cycle, R+1, and otherwise `branch`=0 and `branch_taken`=0.
- `target_address` holds its last value when `branch`=0.
- Flush is registered. It asserts from R+1 for `FLUSH_CYCLES` cycles.
- The counters update at R+1.
- Latency from CF in EX with ready operands to the redirect strobe is 1 cycle. Each WAIT cycle adds one cycle.
- Simultaneous events:
  - A CF arriving during FLUSH is squashed, not resolved.
  - A CF in IDLE with `operand_ready` rising in the same cycle resolves immediately and never enters WAIT.

## Structure
- Shared package `mips_pkg`:
  - State enum `br_state_t` (IDLE/WAIT/FLUSH).
  - Constant `PC_INC` = 4.
  - Helper function `br_target(pc, imm)`.
- One natural sub-module is `sat_counter` (parameter `W`; ports `inc`, `clr`, `q`), instantiated twice.

## Test plan
- **BEQ taken.** Stimulus: `ex_pc`=0x100, `ex_imm`=0x0004, `rs`=`rt`=5, ready. Required response, cycle after R: `branch`=1, `branch_taken`=1, `target`=0x114. Then flush for 2 cycles, `taken_count`=1.
- **BNE not taken, negative offset.** Stimulus: `ex_pc`=0x200, `ex_imm`=0xFFFE, `rs`=`rt`=7. Required response: `branch`=1, `branch_taken`=0, `target`=0x204, no flush, `branch_count`=1, `taken_count`=0.
- **Operand stall.** Stimulus: BEQ with `operand_ready`=0 for 3 cycles. Required response: `stall_ex`=1 for exactly 3 cycles, then the strobe arrives 1 cycle after ready rises.
- **Jump and wrap-around.**
  - J with `ex_pc`=0xF0000000, `ex_jidx`=0x0000010 gives `target`=0xF0000040.
  - BEQ at `ex_pc`=0xFFFFFFFC, `ex_imm`=0 gives `target`=0x00000000.
- **Wrong-path squash and reset.**
  - A second CF presented during FLUSH produces no strobe and no count change.
  - With `CNT_W`=2, 5 taken branches leave `taken_count`=3 (saturated).
  - `rst` asserted during WAIT clears all outputs on the next edge.
